// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32 control unit: opcodes, AMO selectors, ALU ops, immediate formats.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLL    = 4'b0110,
    ALU_SRL    = 4'b0111,
    ALU_SRA    = 4'b1000,
    ALU_PASS_A = 4'b1001
  } alu_op_t;

  // alt selects SUB/SRA; callers mask it for I-type so only SRAI honours it.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lr_sc_reservation.sv
// Single word-granular LR/SC reservation with a bounded lifetime.
// Cleared by SC, by a store hitting the reserved word, by reset, or on timeout.
module lr_sc_reservation
  import ctrl_pkg::*;
#(
  parameter int RES_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_lr,
  input  logic        is_sc,
  input  logic        is_sw,
  input  logic [31:0] alu_result,
  output logic        reserved_flag
);

  localparam logic [CNT_W-1:0] LIFETIME = CNT_W'(RES_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             res_valid;
  logic [29:0]      res_addr;
  logic [CNT_W-1:0] res_cnt;
  logic             unused_byte_offset;

  assign unused_byte_offset = ^alu_result[1:0];
  assign reserved_flag      = res_valid && (res_addr == alu_result[31:2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_cnt   <= '0;
    end else if (is_lr) begin
      res_valid <= 1'b1;
      res_addr  <= alu_result[31:2];
      res_cnt   <= LIFETIME;
    end else if (is_sc) begin
      res_valid <= 1'b0;
    end else if (is_sw && reserved_flag) begin
      res_valid <= 1'b0;
    end else if (res_valid) begin
      // Lifetime counts every cycle after the LR, including stores to other words.
      res_cnt <= res_cnt - ONE;
      if (res_cnt == ONE) res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/control_unit.sv
// RV32 single-cycle decode into datapath controls, plus the LR.W/SC.W reservation tracker.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int RES_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic [31:0] alu_result,
  output logic        pc_src,
  output logic        mem_write,
  output logic [3:0]  alu_control,
  output logic        alu_src,
  output logic [1:0]  imm_src,
  output logic        reg_write,
  output logic        result_src,
  output logic        atomic_flag,
  output logic        reserved_flag
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] f5;
  logic       alt;
  logic       is_lr;
  logic       is_sc;
  logic       is_sw;
  logic       res_hit;
  logic       unused_insn;

  assign opcode      = instruction[6:0];
  assign f3          = instruction[14:12];
  assign f5          = instruction[31:27];
  assign alt         = instruction[30];
  assign unused_insn = ^{instruction[26:15], instruction[11:7]};

  assign is_lr = (opcode == OP_AMO) && (f3 == F3_WORD) && (f5 == F5_LR);
  assign is_sc = (opcode == OP_AMO) && (f3 == F3_WORD) && (f5 == F5_SC);
  assign is_sw = (opcode == OP_STORE) && (f3 == F3_WORD);

  lr_sc_reservation #(
    .RES_TIMEOUT(RES_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_res (
    .clk          (clk),
    .reset        (reset),
    .is_lr        (is_lr),
    .is_sc        (is_sc),
    .is_sw        (is_sw),
    .alu_result   (alu_result),
    .reserved_flag(res_hit)
  );

  always_comb begin
    logic legal;
    legal         = 1'b0;
    pc_src        = 1'b0;
    mem_write     = 1'b0;
    alu_control   = ALU_ADD;
    alu_src       = 1'b0;
    imm_src       = IMM_I;
    reg_write     = 1'b0;
    result_src    = 1'b0;
    atomic_flag   = 1'b0;
    reserved_flag = res_hit;

    case (opcode)
      OP_R: begin
        legal       = (f3 != F3_SLTU);
        reg_write   = 1'b1;
        alu_control = alu_decode(f3, alt);
      end
      OP_I: begin
        legal       = (f3 != F3_SLTU);
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = alu_decode(f3, alt && (f3 == 3'b101));
      end
      OP_LOAD: begin
        legal      = (f3 == F3_WORD);
        alu_src    = 1'b1;
        result_src = 1'b1;
        reg_write  = 1'b1;
      end
      OP_STORE: begin
        legal     = is_sw;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
        mem_write = 1'b1;
      end
      OP_BRANCH: begin
        legal       = (f3 == F3_BEQ);
        imm_src     = IMM_B;
        alu_control = ALU_SUB;
        pc_src      = zero;
      end
      OP_AMO: begin
        legal       = is_lr || is_sc;
        alu_control = ALU_PASS_A;
        atomic_flag = 1'b1;
        reg_write   = 1'b1;
        result_src  = is_lr;
        mem_write   = is_sc && res_hit;
      end
      default: legal = 1'b0;
    endcase

    // Unrecognised encodings and reset both present an all-zero control bus.
    if (reset || !legal) begin
      pc_src        = 1'b0;
      mem_write     = 1'b0;
      alu_control   = ALU_ADD;
      alu_src       = 1'b0;
      imm_src       = IMM_I;
      reg_write     = 1'b0;
      result_src    = 1'b0;
      atomic_flag   = 1'b0;
      reserved_flag = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode vectors, LR/SC reservation lifetime, store and reset clears.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic [31:0] alu_result;
  logic        pc_src, mem_write, alu_src, reg_write, result_src, atomic_flag, reserved_flag;
  logic [3:0]  alu_control;
  logic [1:0]  imm_src;

  int n_cmp = 0;
  int n_bad = 0;

  control_unit #(.RES_TIMEOUT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .zero         (zero),
    .alu_result   (alu_result),
    .pc_src       (pc_src),
    .mem_write    (mem_write),
    .alu_control  (alu_control),
    .alu_src      (alu_src),
    .imm_src      (imm_src),
    .reg_write    (reg_write),
    .result_src   (result_src),
    .atomic_flag  (atomic_flag),
    .reserved_flag(reserved_flag)
  );

  always #5 clk = ~clk;

  // Bus order: pc_src mem_write alu_control[3:0] alu_src imm_src[1:0] reg_write result_src atomic reserved
  function automatic logic [12:0] ex(input logic pc, input logic mw, input logic [3:0] alu,
                                     input logic asrc, input logic [1:0] imm, input logic rw,
                                     input logic rs, input logic at, input logic rf);
    return {pc, mw, alu, asrc, imm, rw, rs, at, rf};
  endfunction

  function automatic logic [31:0] amo(input logic [4:0] f5);
    return {f5, 2'b00, 5'd11, 5'd10, 3'b010, 5'd5, 7'b0101111};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %013b expected %013b", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] bus();
    return {pc_src, mem_write, alu_control, alu_src, imm_src, reg_write, result_src,
            atomic_flag, reserved_flag};
  endfunction

  // Drive away from the rising edge, sample 2 ns later; the next rising edge commits state.
  task automatic apply(input logic rst, input logic [31:0] ins, input logic [31:0] addr,
                       input logic z);
    @(negedge clk);
    reset       = rst;
    instruction = ins;
    alu_result  = addr;
    zero        = z;
    #2;
  endtask

  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_SUB  = {7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] I_XOR  = {7'b0000000, 5'd3, 5'd2, 3'b100, 5'd1, 7'b0110011};
  localparam logic [31:0] I_ADDI = {12'h400, 5'd2, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] I_SRAI = {7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1, 7'b0010011};
  localparam logic [31:0] I_LW   = {12'd0, 5'd2, 3'b010, 5'd1, 7'b0000011};

  logic [12:0] e_sw, e_nop, e_lr, e_sc_ok, e_sc_fail;
  logic [31:0] i_lr, i_sc, i_amoswap;

  initial begin
    e_sw      = ex(0, 1, 4'd0, 1, 2'b01, 0, 0, 0, 0);
    e_nop     = ex(0, 0, 4'd0, 1, 2'b00, 1, 0, 0, 0);
    e_lr      = ex(0, 0, 4'd9, 0, 2'b00, 1, 1, 1, 0);
    e_sc_ok   = ex(0, 1, 4'd9, 0, 2'b00, 1, 0, 1, 1);
    e_sc_fail = ex(0, 0, 4'd9, 0, 2'b00, 1, 0, 1, 0);
    i_lr      = amo(5'b00010);
    i_sc      = amo(5'b00011);
    i_amoswap = amo(5'b00001);

    reset = 1'b1; instruction = I_SW; alu_result = 32'h0; zero = 1'b0;
    apply(1, I_SW, 32'h0, 0);
    check("reset_all_zero", bus(), 13'd0);

    apply(0, I_SW, 32'h0, 0);
    check("sw_decode", bus(), e_sw);
    apply(0, I_BEQ, 32'h0, 1);
    check("beq_taken", bus(), ex(1, 0, 4'd1, 0, 2'b10, 0, 0, 0, 0));
    apply(0, I_BEQ, 32'h0, 0);
    check("beq_not_taken", bus(), ex(0, 0, 4'd1, 0, 2'b10, 0, 0, 0, 0));
    apply(0, I_SUB, 32'h0, 0);
    check("r_sub", bus(), ex(0, 0, 4'd1, 0, 2'b00, 1, 0, 0, 0));
    apply(0, I_XOR, 32'h0, 0);
    check("r_xor", bus(), ex(0, 0, 4'd4, 0, 2'b00, 1, 0, 0, 0));
    apply(0, I_ADDI, 32'h0, 0);
    check("addi_bit30_is_add", bus(), e_nop);
    apply(0, I_SRAI, 32'h0, 0);
    check("srai", bus(), ex(0, 0, 4'd8, 1, 2'b00, 1, 0, 0, 0));
    apply(0, I_LW, 32'h0, 0);
    check("lw", bus(), ex(0, 0, 4'd0, 1, 2'b00, 1, 1, 0, 0));

    apply(0, i_lr, 32'h100, 0);
    check("lr_100", bus(), e_lr);
    apply(0, i_sc, 32'h100, 0);
    check("sc_after_lr_ok", bus(), e_sc_ok);
    apply(0, i_sc, 32'h100, 0);
    check("second_sc_fails", bus(), e_sc_fail);

    apply(0, i_lr, 32'h100, 0);
    check("lr_100_again", bus(), e_lr);
    apply(0, I_SW, 32'h104, 0);
    check("sw_other_word", bus(), e_sw);
    apply(0, I_SW, 32'h100, 0);
    check("sw_same_word_hit", bus(), ex(0, 1, 4'd0, 1, 2'b01, 0, 0, 0, 1));
    apply(0, i_sc, 32'h100, 0);
    check("sc_after_sw_clear", bus(), e_sc_fail);

    apply(0, i_lr, 32'h200, 0);
    check("lr_200", bus(), e_lr);
    for (int i = 0; i < 3; i++) begin
      apply(0, I_NOP, 32'h0, 0);
      check("nop_gap3", bus(), e_nop);
    end
    apply(0, i_sc, 32'h200, 0);
    check("sc_at_timeout_ok", bus(), e_sc_ok);

    apply(0, i_lr, 32'h200, 0);
    check("lr_200_again", bus(), e_lr);
    for (int i = 0; i < 4; i++) begin
      apply(0, I_NOP, 32'h0, 0);
      check("nop_gap4", bus(), e_nop);
    end
    apply(0, i_sc, 32'h200, 0);
    check("sc_past_timeout_fails", bus(), e_sc_fail);

    apply(0, i_lr, 32'h300, 0);
    check("lr_300", bus(), e_lr);
    apply(1, i_sc, 32'h300, 0);
    check("reset_pulse_zero", bus(), 13'd0);
    apply(0, i_sc, 32'h300, 0);
    check("sc_after_reset_fails", bus(), e_sc_fail);
    apply(0, i_amoswap, 32'h300, 0);
    check("amoswap_illegal", bus(), 13'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
